// File: rtl/dmac_axi_rd_arbiter_pkg.sv
// Shared definitions for the DMAC AXI read-port arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE -> AR_PH -> R_PH -> IDLE)
//   AXI_*_W     : AXI3 field widths used on the AR channel
package dmac_arb_pkg;

  localparam int AXI_LEN_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AR_PH = 2'd1,
    R_PH  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmac_axi_rd_arbiter_rr_picker.sv
// Combinational round-robin priority encoder.
//   req  : request vector, one bit per master
//   last : index of the master granted most recently
//   pick : first requesting index after last, wrapping modulo N_MASTER
//   any  : at least one request bit is set
module dmac_rr_picker #(
  parameter int N_MASTER = 2,
  parameter int IDX_W    = $clog2(N_MASTER)
) (
  input  logic [N_MASTER-1:0] req,
  input  logic [IDX_W-1:0]    last,
  output logic [IDX_W-1:0]    pick,
  output logic                any
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Walk the masters in order last+1, last+2, ..., last (the previous
  // winner gets lowest priority); the first requester seen wins.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    any   = |req;
    for (int k = 1; k <= N_MASTER; k++) begin
      idx = IDX_W'((int'(last) + k) % N_MASTER);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmac_axi_rd_arbiter.sv
// Shares one AXI3 read port (AR + R) between N_MASTER requesters with
// round-robin arbitration and a single burst outstanding. The grant is
// held from AR selection until the R beat carrying rlast. R payload is
// broadcast to all masters; only the granted master sees rvalid.
//   clk, rst_n          : clock, synchronous active-low reset
//   m_ar*               : per-master AR channels (master i in slice i)
//   m_r*                : per-master rvalid/rready, shared R payload
//   s_ar*, s_r*         : slave-side AR and R channels
//   grant               : current / last granted master index
//   busy                : a burst is in progress (AR_PH or R_PH)
//   len_err             : pulse on a beat whose rlast disagrees with arlen
//
// Handshake semantics: every channel follows AXI valid/ready rules; a
// transfer occurs on a rising edge where valid and ready are both high,
// and a valid, once raised, must hold with stable payload until ready.
module dmac_axi_rd_arbiter
  import dmac_arb_pkg::*;
#(
  parameter int N_MASTER   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  localparam int IDX_W     = $clog2(N_MASTER)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_MASTER-1:0]               m_arvalid,
  output logic [N_MASTER-1:0]               m_arready,
  input  logic [N_MASTER*ID_WIDTH-1:0]      m_arid,
  input  logic [N_MASTER*ADDR_WIDTH-1:0]    m_araddr,
  input  logic [N_MASTER*AXI_LEN_W-1:0]     m_arlen,
  input  logic [N_MASTER*AXI_SIZE_W-1:0]    m_arsize,
  input  logic [N_MASTER*AXI_BURST_W-1:0]   m_arburst,
  output logic [N_MASTER-1:0]               m_rvalid,
  input  logic [N_MASTER-1:0]               m_rready,
  output logic [ID_WIDTH-1:0]               m_rid,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [1:0]                        m_rresp,
  output logic                              m_rlast,
  output logic                              s_arvalid,
  input  logic                              s_arready,
  output logic [ID_WIDTH-1:0]               s_arid,
  output logic [ADDR_WIDTH-1:0]             s_araddr,
  output logic [AXI_LEN_W-1:0]              s_arlen,
  output logic [AXI_SIZE_W-1:0]             s_arsize,
  output logic [AXI_BURST_W-1:0]            s_arburst,
  input  logic                              s_rvalid,
  output logic                              s_rready,
  input  logic [ID_WIDTH-1:0]               s_rid,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic [1:0]                        s_rresp,
  input  logic                              s_rlast,
  output logic [IDX_W-1:0]                  grant,
  output logic                              busy,
  output logic                              len_err
);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     grant_q, last_grant_q, pick;
  logic                 any_req;
  logic [AXI_LEN_W-1:0] beat_cnt_q, len_q;
  logic                 ar_hs, r_hs;

  dmac_rr_picker #(.N_MASTER(N_MASTER), .IDX_W(IDX_W)) u_picker (
    .req  (m_arvalid),
    .last (last_grant_q),
    .pick (pick),
    .any  (any_req)
  );

  // AR payload is muxed from the granted slice at all times; only
  // s_arvalid is qualified by state.
  assign s_arid    = m_arid   [int'(grant_q)*ID_WIDTH    +: ID_WIDTH];
  assign s_araddr  = m_araddr [int'(grant_q)*ADDR_WIDTH  +: ADDR_WIDTH];
  assign s_arlen   = m_arlen  [int'(grant_q)*AXI_LEN_W   +: AXI_LEN_W];
  assign s_arsize  = m_arsize [int'(grant_q)*AXI_SIZE_W  +: AXI_SIZE_W];
  assign s_arburst = m_arburst[int'(grant_q)*AXI_BURST_W +: AXI_BURST_W];

  // R payload is a zero-latency broadcast; rid is never remapped.
  assign m_rid   = s_rid;
  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    case (state_q)
      AR_PH: begin
        s_arvalid          = m_arvalid[grant_q];
        m_arready[grant_q] = s_arready;
      end
      R_PH: begin
        m_rvalid[grant_q] = s_rvalid;
        s_rready          = m_rready[grant_q];
      end
      default: ;
    endcase
  end

  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid & s_rready;

  // Beat index beat_cnt_q == len_q is the one that must carry rlast.
  // A missing rlast there is flagged but the burst still runs until the
  // slave does assert rlast.
  assign len_err = r_hs & (s_rlast ? (beat_cnt_q != len_q)
                                   : (beat_cnt_q == len_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)        state_d = AR_PH;
      AR_PH:   if (ar_hs)          state_d = R_PH;
      R_PH:    if (r_hs && s_rlast) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N_MASTER - 1);
      beat_cnt_q   <= '0;
      len_q        <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) grant_q <= pick;
      if (ar_hs) begin
        len_q      <= s_arlen;
        beat_cnt_q <= '0;
      end
      if (r_hs) begin
        if (beat_cnt_q != {AXI_LEN_W{1'b1}}) beat_cnt_q <= beat_cnt_q + 1'b1;
        if (s_rlast) last_grant_q <= grant_q;
      end
    end
  end

endmodule

// File: tb/tb_dmac_axi_rd_arbiter.sv
module tb_dmac_axi_rd_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    m_arvalid = '0;
  logic [N-1:0]    m_arready;
  logic [N*IW-1:0] m_arid = '0;
  logic [N*AW-1:0] m_araddr = '0;
  logic [N*4-1:0]  m_arlen = '0;
  logic [N*3-1:0]  m_arsize = '0;
  logic [N*2-1:0]  m_arburst = '0;
  logic [N-1:0]    m_rvalid;
  logic [N-1:0]    m_rready = '0;
  logic [IW-1:0]   m_rid;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic            s_arvalid;
  logic            s_arready = 1'b0;
  logic [IW-1:0]   s_arid;
  logic [AW-1:0]   s_araddr;
  logic [3:0]      s_arlen;
  logic [2:0]      s_arsize;
  logic [1:0]      s_arburst;
  logic            s_rvalid = 1'b0;
  logic            s_rready;
  logic [IW-1:0]   s_rid = '0;
  logic [DW-1:0]   s_rdata = '0;
  logic [1:0]      s_rresp = '0;
  logic            s_rlast = 1'b0;
  logic            grant;
  logic            busy;
  logic            len_err;

  int n_assert = 0;
  int n_fail   = 0;

  dmac_axi_rd_arbiter #(.N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .grant(grant), .busy(busy), .len_err(len_err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // AR stability monitor: once s_arvalid is up without s_arready it must
  // stay up on the next cycle (an arvalid drop in AR_PH is an AXI violation).
  logic ar_pend = 1'b0;
  always @(negedge clk) begin
    #4;
    if (rst_n && ar_pend) begin
      n_assert++;
      if (s_arvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL ar_stable: s_arvalid got %b want 1", s_arvalid);
      end
    end
    ar_pend = rst_n && s_arvalid && !s_arready;
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int m, input logic [31:0] addr, input logic [3:0] len);
    m_arvalid[m]          = 1'b1;
    m_arid[m*IW +: IW]    = IW'(m + 1);
    m_araddr[m*AW +: AW]  = addr;
    m_arlen[m*4 +: 4]     = len;
    m_arsize[m*3 +: 3]    = 3'd2;
    m_arburst[m*2 +: 2]   = 2'b01;
  endtask

  task automatic set_beat(input logic v, input logic [31:0] d, input logic last);
    s_rvalid = v;
    s_rdata  = d;
    s_rlast  = last;
    s_rid    = 4'h5;
    s_rresp  = 2'b00;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_arvalid = '0; m_rready = '0; s_arready = 1'b0;
    set_beat(1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_assert++; if (grant !== 1'b0) begin n_fail++; $display("FAIL rst_grant: got %b want 0", grant); end
    n_assert++; if (s_arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_s_arvalid: got %b want 0", s_arvalid); end
    n_assert++; if (m_arready !== 2'b00) begin n_fail++; $display("FAIL rst_m_arready: got %b want 00", m_arready); end
    n_assert++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL rst_m_rvalid: got %b want 00", m_rvalid); end
    n_assert++; if (s_rready !== 1'b0) begin n_fail++; $display("FAIL rst_s_rready: got %b want 0", s_rready); end
    n_assert++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL rst_len_err: got %b want 0", len_err); end
  endtask

  task automatic test_single_burst();
    set_req(0, 32'h1000, 4'd3);
    s_arready = 1'b0;
    m_rready  = 2'b01;
    #1;
    n_assert++; if (s_arvalid !== 1'b0) begin n_fail++; $display("FAIL sb_idle_arvalid: got %b want 0", s_arvalid); end
    @(negedge clk); #1;
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy: got %b want 1", busy); end
    n_assert++; if (s_arvalid !== 1'b1) begin n_fail++; $display("FAIL sb_arvalid: got %b want 1", s_arvalid); end
    n_assert++; if (s_araddr !== 32'h1000) begin n_fail++; $display("FAIL sb_araddr: got %h want 00001000", s_araddr); end
    n_assert++; if (s_arlen !== 4'd3) begin n_fail++; $display("FAIL sb_arlen: got %0d want 3", s_arlen); end
    n_assert++; if (m_arready !== 2'b00) begin n_fail++; $display("FAIL sb_arready_wait: got %b want 00", m_arready); end
    @(negedge clk); #1;   // slave wait state: request must still be held
    n_assert++; if (s_arvalid !== 1'b1) begin n_fail++; $display("FAIL sb_arvalid_hold: got %b want 1", s_arvalid); end
    s_arready = 1'b1;
    #1;
    n_assert++; if (m_arready !== 2'b01) begin n_fail++; $display("FAIL sb_arready: got %b want 01", m_arready); end
    @(negedge clk);
    m_arvalid = '0;
    s_arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      set_beat(1'b1, 32'hA0 + 32'(b), (b == 3));
      #1;
      n_assert++; if (m_rvalid !== 2'b01) begin n_fail++; $display("FAIL sb_rvalid beat %0d: got %b want 01", b, m_rvalid); end
      n_assert++; if (m_rdata !== 32'hA0 + 32'(b)) begin n_fail++; $display("FAIL sb_rdata beat %0d: got %h want %h", b, m_rdata, 32'hA0 + 32'(b)); end
      n_assert++; if (s_rready !== 1'b1) begin n_fail++; $display("FAIL sb_rready beat %0d: got %b want 1", b, s_rready); end
      n_assert++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL sb_len_err beat %0d: got %b want 0", b, len_err); end
      @(negedge clk);
    end
    set_beat(1'b0, 32'h0, 1'b0);
    #1;
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sb_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0] oh;
    apply_reset();
    set_req(0, 32'h2000, 4'd0);
    set_req(1, 32'h3000, 4'd0);
    s_arready = 1'b1;
    m_rready  = 2'b11;
    #1;
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_start_busy: got %b want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      oh = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk); #1;
      n_assert++; if (grant !== 1'(i % 2)) begin n_fail++; $display("FAIL rr_grant burst %0d: got %0d want %0d", i, grant, i % 2); end
      n_assert++; if (m_arready !== oh) begin n_fail++; $display("FAIL rr_arready burst %0d: got %b want %b", i, m_arready, oh); end
      n_assert++; if (s_araddr !== ((i % 2 == 0) ? 32'h2000 : 32'h3000)) begin n_fail++; $display("FAIL rr_araddr burst %0d: got %h", i, s_araddr); end
      @(negedge clk);
      set_beat(1'b1, 32'hB0 + 32'(i), 1'b1);
      #1;
      n_assert++; if (m_rvalid !== oh) begin n_fail++; $display("FAIL rr_rvalid burst %0d: got %b want %b", i, m_rvalid, oh); end
      n_assert++; if (m_arready !== 2'b00) begin n_fail++; $display("FAIL rr_ar_ignored burst %0d: got %b want 00", i, m_arready); end
      @(negedge clk);
      set_beat(1'b0, 32'h0, 1'b0);
      #1;
      n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_bubble burst %0d: busy got %b want 0", i, busy); end
    end
  endtask

  task automatic test_single_requester();
    m_arvalid = '0;
    set_req(1, 32'h4000, 4'd0);
    m_rready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_assert++; if (grant !== 1'b1) begin n_fail++; $display("FAIL sr_grant burst %0d: got %0d want 1", i, grant); end
      n_assert++; if (s_arid !== 4'd2) begin n_fail++; $display("FAIL sr_arid burst %0d: got %0d want 2", i, s_arid); end
      @(negedge clk);
      set_beat(1'b1, 32'hD00 + 32'(i), 1'b1);
      #1;
      n_assert++; if (m_rvalid !== 2'b10) begin n_fail++; $display("FAIL sr_rvalid burst %0d: got %b want 10", i, m_rvalid); end
      n_assert++; if (m_rid !== 4'h5) begin n_fail++; $display("FAIL sr_rid burst %0d: got %h want 5", i, m_rid); end
      @(negedge clk);
      set_beat(1'b0, 32'h0, 1'b0);
      #1;
      n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sr_bubble burst %0d: got %b want 0", i, busy); end
    end
  endtask

  task automatic test_early_rlast();
    m_arvalid = '0;
    set_req(0, 32'h5000, 4'd3);
    m_rready = 2'b01;
    @(negedge clk); #1;
    n_assert++; if (grant !== 1'b0) begin n_fail++; $display("FAIL er_grant: got %0d want 0", grant); end
    n_assert++; if (s_arlen !== 4'd3) begin n_fail++; $display("FAIL er_arlen: got %0d want 3", s_arlen); end
    @(negedge clk);
    m_arvalid = '0;
    set_beat(1'b1, 32'hC0, 1'b0);
    #1;
    n_assert++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL er_err_beat1: got %b want 0", len_err); end
    @(negedge clk);
    set_beat(1'b1, 32'hC1, 1'b1);
    #1;
    n_assert++; if (len_err !== 1'b1) begin n_fail++; $display("FAIL er_err_beat2: got %b want 1", len_err); end
    @(negedge clk);
    set_beat(1'b0, 32'h0, 1'b0);
    #1;
    n_assert++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL er_err_after: got %b want 0", len_err); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL er_idle: busy got %b want 0", busy); end
    set_req(1, 32'h6000, 4'd0);
    m_rready = 2'b10;
    @(negedge clk); #1;
    n_assert++; if (grant !== 1'b1) begin n_fail++; $display("FAIL er_next_grant: got %0d want 1", grant); end
    n_assert++; if (m_arready !== 2'b10) begin n_fail++; $display("FAIL er_next_arready: got %b want 10", m_arready); end
    @(negedge clk);
    m_arvalid = '0;
    set_beat(1'b1, 32'hC2, 1'b1);
    #1;
    n_assert++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL er_next_err: got %b want 0", len_err); end
    @(negedge clk);
    set_beat(1'b0, 32'h0, 1'b0);
    #1;
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL er_next_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_late_rlast();
    set_req(0, 32'h7000, 4'd1);
    m_rready = 2'b01;
    @(negedge clk); #1;
    n_assert++; if (s_arlen !== 4'd1) begin n_fail++; $display("FAIL lr_arlen: got %0d want 1", s_arlen); end
    @(negedge clk);
    m_arvalid = '0;
    set_beat(1'b1, 32'hD0, 1'b0);
    #1;
    n_assert++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL lr_err_beat1: got %b want 0", len_err); end
    @(negedge clk);
    set_beat(1'b1, 32'hD1, 1'b0);
    #1;
    n_assert++; if (len_err !== 1'b1) begin n_fail++; $display("FAIL lr_err_beat2: got %b want 1", len_err); end
    @(negedge clk);
    set_beat(1'b1, 32'hD2, 1'b1);
    #1;
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lr_still_busy: got %b want 1", busy); end
    n_assert++; if (m_rvalid !== 2'b01) begin n_fail++; $display("FAIL lr_rvalid_beat3: got %b want 01", m_rvalid); end
    @(negedge clk);
    set_beat(1'b0, 32'h0, 1'b0);
    #1;
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lr_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_burst();
    set_req(1, 32'h8000, 4'd7);
    m_rready = 2'b10;
    @(negedge clk); #1;
    n_assert++; if (grant !== 1'b1) begin n_fail++; $display("FAIL rm_grant: got %0d want 1", grant); end
    @(negedge clk);
    m_arvalid = '0;
    set_beat(1'b1, 32'hE0, 1'b0);
    #1;
    n_assert++; if (m_rvalid !== 2'b10) begin n_fail++; $display("FAIL rm_rvalid_beat1: got %b want 10", m_rvalid); end
    @(negedge clk);
    set_beat(1'b1, 32'hE1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_rready = 2'b11;   // keep R inputs active so gating in IDLE is visible
    #1;
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_assert++; if (grant !== 1'b0) begin n_fail++; $display("FAIL rm_grant_rst: got %0d want 0", grant); end
    n_assert++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL rm_rvalid: got %b want 00", m_rvalid); end
    n_assert++; if (s_rready !== 1'b0) begin n_fail++; $display("FAIL rm_rready: got %b want 0", s_rready); end
    n_assert++; if (s_arvalid !== 1'b0) begin n_fail++; $display("FAIL rm_arvalid: got %b want 0", s_arvalid); end
    n_assert++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL rm_len_err: got %b want 0", len_err); end
    set_beat(1'b0, 32'h0, 1'b0);
    set_req(0, 32'h9000, 4'd0);
    set_req(1, 32'hA000, 4'd0);
    m_rready = 2'b01;
    @(negedge clk); #1;
    n_assert++; if (grant !== 1'b0) begin n_fail++; $display("FAIL rm_post_grant: got %0d want 0", grant); end
    n_assert++; if (m_arready !== 2'b01) begin n_fail++; $display("FAIL rm_post_arready: got %b want 01", m_arready); end
    n_assert++; if (s_araddr !== 32'h9000) begin n_fail++; $display("FAIL rm_post_araddr: got %h want 00009000", s_araddr); end
    @(negedge clk);
    m_arvalid = '0;
    set_beat(1'b1, 32'hF0, 1'b1);
    #1;
    n_assert++; if (m_rvalid !== 2'b01) begin n_fail++; $display("FAIL rm_post_rvalid: got %b want 01", m_rvalid); end
    @(negedge clk);
    set_beat(1'b0, 32'h0, 1'b0);
    #1;
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_post_idle: busy got %b want 0", busy); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_single_requester();
    test_early_rlast();
    test_late_rlast();
    test_reset_mid_burst();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
